// File: rtl/parking_gate_scheduler.sv
// Shared barrier-door scheduler for a small parking lot: arbitrates entry/exit
// requesters, owns the slot occupancy vector and times each door opening.
module parking_gate_scheduler #(
    parameter int SLOTS       = 4,
    parameter int SLOT_W      = 2,
    parameter int OPEN_CYCLES = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              entry_req,
    input  logic              exit_req,
    input  logic [SLOT_W-1:0] exit_slot,
    output logic              entry_grant,
    output logic              exit_grant,
    output logic              reject,
    output logic [SLOT_W-1:0] assigned_slot,
    output logic [SLOTS-1:0]  occupancy,
    output logic              door_open,
    output logic              full,
    output logic              busy
);

    localparam int TIMER_W = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
    localparam int IDX_N   = 1 << SLOT_W;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ENTRY_OPEN = 2'd1,
        EXIT_OPEN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SLOTS-1:0]    occupancy_q, occupancy_d;
    logic [SLOT_W-1:0]   assigned_q, assigned_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                prio_exit_q, prio_exit_d;
    logic                door_q, door_d;
    logic                busy_q, busy_d;

    logic [IDX_N-1:0]    occ_ext_s;
    logic [SLOT_W-1:0]   free_idx_s;
    logic                full_s;
    logic                entry_elig_s;
    logic                exit_valid_s;
    logic                entry_win_s;
    logic                exit_win_s;
    logic                reject_s;

    assign full_s = &occupancy_q;

    // Lowest free slot, plus an index-wide occupancy view so that slot numbers
    // beyond SLOTS read as unoccupied.
    always_comb begin
        occ_ext_s              = '0;
        occ_ext_s[SLOTS-1:0]   = occupancy_q;
        free_idx_s             = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!occupancy_q[i]) begin
                free_idx_s = SLOT_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    // Arbitration and next-state logic.
    always_comb begin
        state_d      = state_q;
        occupancy_d  = occupancy_q;
        assigned_d   = assigned_q;
        timer_d      = timer_q;
        prio_exit_d  = prio_exit_q;
        door_d       = door_q;
        busy_d       = busy_q;
        entry_elig_s = 1'b0;
        exit_valid_s = 1'b0;
        entry_win_s  = 1'b0;
        exit_win_s   = 1'b0;
        reject_s     = 1'b0;
        case (state_q)
            IDLE: begin
                entry_elig_s = entry_req & ~full_s;
                exit_valid_s = exit_req & occ_ext_s[exit_slot];
                reject_s     = exit_req & ~occ_ext_s[exit_slot];
                if (entry_elig_s && exit_valid_s) begin
                    if (prio_exit_q) begin
                        exit_win_s = 1'b1;
                    end else begin
                        entry_win_s = 1'b1;
                    end
                    prio_exit_d = ~prio_exit_q;
                end else begin
                    entry_win_s = entry_elig_s;
                    exit_win_s  = exit_valid_s;
                end
                if (entry_win_s) begin
                    occupancy_d[free_idx_s] = 1'b1;
                    assigned_d = free_idx_s;
                    timer_d    = TIMER_W'(OPEN_CYCLES - 1);
                    state_d    = ENTRY_OPEN;
                    door_d     = 1'b1;
                    busy_d     = 1'b1;
                end else if (exit_win_s) begin
                    occupancy_d[exit_slot] = 1'b0;
                    timer_d    = TIMER_W'(OPEN_CYCLES - 1);
                    state_d    = EXIT_OPEN;
                    door_d     = 1'b1;
                    busy_d     = 1'b1;
                end else begin
                    state_d    = IDLE;
                end
            end
            ENTRY_OPEN, EXIT_OPEN: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                    door_d  = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                door_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            occupancy_q <= '0;
            assigned_q  <= '0;
            timer_q     <= '0;
            prio_exit_q <= 1'b0;
            door_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            occupancy_q <= occupancy_d;
            assigned_q  <= assigned_d;
            timer_q     <= timer_d;
            prio_exit_q <= prio_exit_d;
            door_q      <= door_d;
            busy_q      <= busy_d;
        end
    end

    // Decision pulses are suppressed while reset is held.
    assign entry_grant   = entry_win_s & ~rst;
    assign exit_grant    = exit_win_s & ~rst;
    assign reject        = reject_s & ~rst;
    assign assigned_slot = assigned_q;
    assign occupancy     = occupancy_q;
    assign door_open     = door_q;
    assign busy          = busy_q;
    assign full          = full_s;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Self-checking bench: per-cycle behavioural model plus directed scenarios.
module tb_parking_gate_scheduler;

    localparam int SLOTS = 4;
    localparam int SLOT_W = 2;
    localparam int OPEN = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              entry_req = 1'b0;
    logic              exit_req = 1'b0;
    logic [SLOT_W-1:0] exit_slot = '0;
    logic              entry_grant, exit_grant, reject, door_open, full, busy;
    logic [SLOT_W-1:0] assigned_slot;
    logic [SLOTS-1:0]  occupancy;

    int checks = 0;
    int failures = 0;

    parking_gate_scheduler #(.SLOTS(SLOTS), .SLOT_W(SLOT_W), .OPEN_CYCLES(OPEN)) dut (
        .clk(clk), .rst(rst), .entry_req(entry_req), .exit_req(exit_req),
        .exit_slot(exit_slot), .entry_grant(entry_grant), .exit_grant(exit_grant),
        .reject(reject), .assigned_slot(assigned_slot), .occupancy(occupancy),
        .door_open(door_open), .full(full), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: slot array, count of remaining door-open cycles, fairness flag.
    bit [SLOTS-1:0] m_occ = '0;
    int             m_assigned = 0;
    int             m_left = 0;
    bit             m_prio_exit = 1'b0;

    always @(negedge clk) begin
        bit e_eg, e_xg, e_rej, ee, xe, xv, e_full;
        if (rst) begin
            m_occ = '0; m_assigned = 0; m_left = 0; m_prio_exit = 1'b0;
        end
        e_full = &m_occ;
        e_eg = 1'b0; e_xg = 1'b0; e_rej = 1'b0;
        if (!rst && m_left == 0) begin
            xv = (int'(exit_slot) < SLOTS) && m_occ[exit_slot];
            e_rej = exit_req && !xv;
            ee = entry_req && !e_full;
            xe = exit_req && xv;
            if (ee && xe) begin
                if (m_prio_exit) e_xg = 1'b1; else e_eg = 1'b1;
                m_prio_exit = !m_prio_exit;
            end else begin
                e_eg = ee;
                e_xg = xe;
            end
        end
        chk("m_entry_grant", 32'(entry_grant), 32'(e_eg));
        chk("m_exit_grant", 32'(exit_grant), 32'(e_xg));
        chk("m_reject", 32'(reject), 32'(e_rej));
        chk("m_assigned", 32'(assigned_slot), 32'(m_assigned));
        chk("m_occupancy", 32'(occupancy), 32'(m_occ));
        chk("m_door_open", 32'(door_open), 32'(m_left > 0));
        chk("m_busy", 32'(busy), 32'(m_left > 0));
        chk("m_full", 32'(full), 32'(e_full));
        if (!rst) begin
            if (e_eg) begin
                for (int k = 0; k < SLOTS; k++) begin
                    if (!m_occ[k]) begin
                        m_occ[k] = 1'b1;
                        m_assigned = k;
                        break;
                    end
                end
                m_left = OPEN;
            end else if (e_xg) begin
                m_occ[exit_slot] = 1'b0;
                m_left = OPEN;
            end else if (m_left > 0) begin
                m_left--;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: return entry_grant;
            1: return exit_grant;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string name);
        int n = 0;
        while (!sig(sel) && n < 200) begin
            step();
            n++;
        end
        chk(name, 32'(sig(sel)), 32'd1);
    endtask

    task automatic count_door(input string name);
        int n = 0;
        while (door_open && n < 100) begin
            step();
            n++;
        end
        chk(name, 32'(n), 32'(OPEN));
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_entry(input int exp_slot);
        entry_req = 1'b1;
        #1;
        wait_for(0, "entry_grant_wait");
        step();
        entry_req = 1'b0;
        chk("entry_assigned", 32'(assigned_slot), 32'(exp_slot));
        count_door("entry_door_cycles");
    endtask

    task automatic do_exit(input int slot);
        exit_req = 1'b1;
        exit_slot = SLOT_W'(slot);
        #1;
        wait_for(1, "exit_grant_wait");
        step();
        exit_req = 1'b0;
        count_door("exit_door_cycles");
    endtask

    initial begin
        repeat (2) step();
        chk("rst_occupancy", 32'(occupancy), 32'h0);
        chk("rst_door", 32'(door_open), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_full", 32'(full), 32'h0);
        rst = 1'b0;
        step();

        // Entry on empty lot
        do_entry(0);
        chk("t2_occ", 32'(occupancy), 32'h1);

        // Build 0101, then lowest-free entry
        do_entry(1);
        do_entry(2);
        do_exit(1);
        chk("t3_pre_occ", 32'(occupancy), 32'h5);
        do_entry(1);
        chk("t3_occ", 32'(occupancy), 32'h7);
        do_entry(3);
        chk("t5_full_occ", 32'(occupancy), 32'hF);

        // Full lot: entry waits, exit served, then entry takes freed slot
        entry_req = 1'b1;
        #1;
        repeat (5) step();
        chk("t5_full", 32'(full), 32'd1);
        chk("t5_no_grant", 32'(entry_grant), 32'd0);
        exit_req = 1'b1;
        exit_slot = 2'd2;
        #1;
        wait_for(1, "t5_exit_grant");
        step();
        exit_req = 1'b0;
        chk("t5_occ_after_exit", 32'(occupancy), 32'hB);
        count_door("t5_exit_door");
        wait_for(0, "t5_entry_grant");
        step();
        entry_req = 1'b0;
        chk("t5_assigned", 32'(assigned_slot), 32'd2);
        count_door("t5_entry_door");

        // Alternating fairness from occupancy 0011
        do_exit(3);
        do_exit(2);
        chk("t4_pre_occ", 32'(occupancy), 32'h3);
        entry_req = 1'b1;
        exit_req = 1'b1;
        exit_slot = 2'd0;
        #1;
        chk("t4_first_entry", 32'(entry_grant), 32'd1);
        chk("t4_first_not_exit", 32'(exit_grant), 32'd0);
        step();
        count_door("t4_door1");
        chk("t4_second_exit", 32'(exit_grant), 32'd1);
        chk("t4_second_not_entry", 32'(entry_grant), 32'd0);
        step();
        count_door("t4_door2");
        chk("t4_third_entry", 32'(entry_grant), 32'd1);
        chk("t4_third_reject", 32'(reject), 32'd1);
        step();
        entry_req = 1'b0;
        exit_req = 1'b0;
        chk("t4_occ", 32'(occupancy), 32'h7);
        count_door("t4_door3");

        // Async reset while the door is open
        entry_req = 1'b1;
        #1;
        wait_for(0, "t1_entry_grant");
        step();
        step();
        #2;
        chk("t1_pre_door", 32'(door_open), 32'd1);
        rst = 1'b1;
        #1;
        chk("t1_door", 32'(door_open), 32'd0);
        chk("t1_occ", 32'(occupancy), 32'h0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_assigned", 32'(assigned_slot), 32'd0);
        chk("t1_grant_gated", 32'(entry_grant), 32'd0);
        step();
        rst = 1'b0;
        entry_req = 1'b0;
        step();

        // Exit of an unoccupied slot is rejected
        exit_req = 1'b1;
        exit_slot = 2'd3;
        #1;
        chk("t6_reject", 32'(reject), 32'd1);
        chk("t6_no_exit_grant", 32'(exit_grant), 32'd0);
        step();
        chk("t6_reject_held", 32'(reject), 32'd1);
        chk("t6_door", 32'(door_open), 32'd0);
        exit_req = 1'b0;
        #1;
        chk("t6_reject_drop", 32'(reject), 32'd0);
        step();
        chk("t6_occ", 32'(occupancy), 32'h0);
        chk("t6_door_after", 32'(door_open), 32'd0);
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
